// File: rtl/tick_clock_gen_pkg.sv
// Shared constants and helpers for the programmable multi-channel tick/clock divider.
package tick_clock_gen_pkg;

  localparam int DEF_DIV_DEFAULT = 100000;
  localparam int MIN_DIV         = 2;

  // Width of a channel index; never narrower than one bit so a single-channel build still has a port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: ratio register, phase counter, registered square wave and tick.
// With TICK_CLOCK_GEN_SYNC_EN defined a sync input restarts the phase of the channel.
module tick_channel
  import tick_clock_gen_pkg::*;
#(
  parameter int WIDTH   = 27,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
`ifdef TICK_CLOCK_GEN_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_div,
  output logic             tick
);

  localparam logic [WIDTH-1:0] MIN_N   = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] RESET_N = WIDTH'(DEF_DIV);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             clk_div_d;
  logic             tick_d;
  logic             restart;

  assign cnt_inc = cnt_q + WIDTH'(1);

`ifdef TICK_CLOCK_GEN_SYNC_EN
  assign restart = sync && (div_q >= MIN_N);
`else
  assign restart = 1'b0;
`endif

  // Load wins over everything; terminal is cnt >= N-1 so a shrunk ratio cannot strand cnt.
  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    clk_div_d = clk_div;
    tick_d    = 1'b0;
    if (load) begin
      div_d     = load_div;
      cnt_d     = '0;
      clk_div_d = 1'b0;
    end else if (restart) begin
      cnt_d     = '0;
      clk_div_d = 1'b0;
    end else if (div_q < MIN_N) begin
      cnt_d     = '0;
      clk_div_d = 1'b0;
    end else if (en) begin
      if (cnt_q >= div_q - WIDTH'(1)) begin
        cnt_d     = '0;
        clk_div_d = 1'b0;
        tick_d    = 1'b1;
      end else begin
        cnt_d     = cnt_inc;
        clk_div_d = (cnt_inc >= (div_q >> 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= RESET_N;
      cnt_q   <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      clk_div <= clk_div_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: rtl/tick_clock_gen.sv
// Multi-channel programmable clock divider producing per-channel square waves and ticks.
// Optional phase alignment of all channels is enabled by defining TICK_CLOCK_GEN_SYNC_EN.
module tick_clock_gen
  import tick_clock_gen_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WIDTH   = 27,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic                   load,
  input  logic [ch_w(NCH)-1:0]   load_ch,
  input  logic [WIDTH-1:0]       load_div,
`ifdef TICK_CLOCK_GEN_SYNC_EN
  input  logic                   sync,
`endif
  output logic [NCH-1:0]         clk_div,
  output logic [NCH-1:0]         tick
);

  localparam int CHW = ch_w(NCH);

  // load is a single-cycle strobe with no back-pressure: it is always accepted on the
  // edge where it is high, and an index at or beyond NCH selects no channel at all.
  logic [NCH-1:0] load_sel;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign load_sel[i] = load && (load_ch == CHW'(i));

    tick_channel #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .load     (load_sel[i]),
      .load_div (load_div),
`ifdef TICK_CLOCK_GEN_SYNC_EN
      .sync     (sync),
`endif
      .clk_div  (clk_div[i]),
      .tick     (tick[i])
    );
  end

endmodule
